chimera_uart_rx_monitor: RTL and testbench
==========================================

// Module: chimera_uart_rx_monitor
// PURPOSE
//  Sim-side UART receiver that consumes the SoC uart_tx line.
//  It sits in the chimera SoC fixture, directly downstream of the DUT's uart_tx output.
//  Deserializes 8N1 frames, buffers the bytes in a small FIFO and hands them to the bench
//  over valid/ready. Flags framing errors and FIFO overflow.
// PARAMETERS
//  BaudDiv    434  clk cycles per UART bit (>=4); 434 = 50 MHz / 115200
//  FifoDepth  8    byte FIFO entries (power of two, >=2)
// PORTS
//  clk_i        in   1                       sampling clock
//  rst_i        in   1                       reset, asynchronous, active-high
//  uart_rx_i    in   1                       serial line from DUT uart_tx; idle high
//  byte_o       out  8                       FIFO head byte
//  valid_o      out  1                       FIFO non-empty
//  ready_i      in   1                       bench pops head when valid_o && ready_i
//  frame_err_o  out  1                       1-cycle pulse: stop bit sampled low
//  overflow_o   out  1                       sticky: byte dropped because FIFO was full
//  busy_o       out  1                       FSM not in IDLE
//  count_o      out  $clog2(FifoDepth+1)     FIFO occupancy
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-high (clk_i, rst_i).
//  Reset values: all outputs 0; byte_o = 8'h00; FSM = IDLE; FIFO empty.
//   Synchronizer flops reset to 1 (line idle).
//  Input sync: 2-flop synchronizer. All decisions use the synced value rx_s.
//  Bit counter: cnt counts 0..BaudDiv-1. Half-bit point = BaudDiv/2 (floor).
//  FSM states and transitions:
//   IDLE:  rx_s==0 -> START; cnt=0.
//   START: at cnt==BaudDiv/2, check rx_s.
//     rx_s==1 -> IDLE (glitch; no pulse, nothing pushed).
//     rx_s==0 -> DATA; cnt=0; bit=0.
//   DATA:  at cnt==BaudDiv-1, sample rx_s into shift reg, LSB first; bit++.
//     After bit 7 -> STOP.
//   STOP:  at cnt==BaudDiv-1, sample rx_s.
//     rx_s==1 -> push byte; go to IDLE.
//     rx_s==0 -> frame_err_o pulses for 1 cycle; byte discarded; go to BREAK.
//   BREAK: stay until rx_s==1, then IDLE (no re-trigger during a held-low line).
//  Timing: samples land at bit centres. Push occurs 2 + BaudDiv/2 + 9*BaudDiv cycles
//   after the falling edge on uart_rx_i (plus cnt phase; tolerance +-1 cycle).
//  FIFO behaviour:
//   valid_o rises the cycle after the push edge.
//   byte_o is registered head data, stable while valid_o && !ready_i.
//   Pop and push in the same cycle: both happen; count unchanged.
//   Push when full without a same-cycle pop: byte dropped; overflow_o set until reset.
//   Pop when empty: ignored.
//   Pointers wrap modulo FifoDepth; count_o saturates at FifoDepth by construction.
//  busy_o = (state != IDLE).
//  Reset mid-frame: FSM to IDLE immediately; partial byte lost; FIFO cleared.
// TESTING (BaudDiv=8, FifoDepth=4 unless noted)
//  1. Send 0x55, 8N1, ready_i=1 -> byte_o=0x55 with valid_o for 1 cycle;
//     push within 2+4+72 +-1 cycles of the start edge.
//  2. Send 0x00,0xFF,0xA5,0x3C back-to-back, ready_i=0 -> count_o=4;
//     pops return the bytes in order; overflow_o stays 0.
//  3. Send 5 bytes with ready_i=0 -> 5th byte dropped; overflow_o=1 (sticky);
//     FIFO holds the first 4.
//  4. Send frame 0xC3 with stop bit forced low for 16 cycles
//     -> frame_err_o pulses once; nothing pushed; busy_o stays 1 until the line returns high.
//  5. 3-cycle low glitch on idle line -> returns to IDLE, no push, no frame_err_o.
//  6. Assert rst_i during DATA bit 4 -> outputs 0 and busy_o=0 immediately;
//     next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/chimera_uart_rx_monitor.sv
// Sim-side 8N1 UART receiver: 2-flop sync, mid-bit sampling FSM, byte FIFO handed out over valid/ready.
// Stop-bit errors pulse frame_err_o; bytes arriving at a full FIFO are dropped and flagged sticky.
module chimera_uart_rx_monitor #(
  parameter int BaudDiv   = 434,
  parameter int FifoDepth = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               uart_rx_i,
  output logic [7:0]                         byte_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic                               frame_err_o,
  output logic                               overflow_o,
  output logic                               busy_o,
  output logic [$clog2(FifoDepth+1)-1:0]     count_o
);

  localparam int CntW  = $clog2(BaudDiv);
  localparam int PtrW  = $clog2(FifoDepth);
  localparam int OccW  = $clog2(FifoDepth + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(BaudDiv - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(BaudDiv / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic            rx_meta_q, rx_s_q;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_req, frame_err_d;

  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OccW-1:0] count_q, count_d;
  logic [7:0]      byte_q, byte_d;
  logic            ovf_q, ovf_d, fe_q;
  logic            full, pop, do_push;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // The detection cycle already lies inside the start bit, so it is counted.
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = CntW'(1);
        end
      end
      S_START: begin
        if (cnt_q == CntHalf) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == CntLast) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = '0;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      fe_q    <= frame_err_d;
    end
  end

  assign full    = (count_q == OccW'(FifoDepth));
  assign pop     = (count_q != '0) && ready_i;
  assign do_push = push_req && (!full || pop);

  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    if (do_push && !pop) count_d = count_q + 1'b1;
    else if (pop && !do_push) count_d = count_q - 1'b1;
    ovf_d = ovf_q | (push_req && full && !pop);
    // Head is registered; a byte landing in an otherwise empty FIFO bypasses storage.
    byte_d = 8'h00;
    if (do_push && count_d == OccW'(1)) byte_d = shift_q;
    else if (count_d != '0) byte_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      byte_q   <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      byte_q   <= byte_d;
      ovf_q    <= ovf_d;
    end
  end

  assign byte_o      = byte_q;
  assign valid_o     = (count_q != '0);
  assign count_o     = count_q;
  assign frame_err_o = fe_q;
  assign overflow_o  = ovf_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_chimera_uart_rx_monitor.sv
// Directed bench for chimera_uart_rx_monitor with BaudDiv=8, FifoDepth=4.
module tb_chimera_uart_rx_monitor;

  localparam int B = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] byte_o;
  logic       valid_o, frame_err_o, overflow_o, busy_o;
  logic [2:0] count_o;

  int checks = 0;
  int errors = 0;
  int fe_seen = 0;
  int valid_seen = 0;
  int lat = 0;

  typedef struct {
    logic [7:0] tx;
    logic [2:0] exp_count;
    logic       exp_ovf;
  } fill_vec_t;

  fill_vec_t  fill_tbl [5];
  logic [7:0] pop_tbl [4];
  logic [7:0] pat_tbl [3];

  always #5 clk = ~clk;

  chimera_uart_rx_monitor #(.BaudDiv(B), .FifoDepth(D)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .uart_rx_i  (uart_rx),
    .byte_o     (byte_o),
    .valid_o    (valid_o),
    .ready_i    (ready),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .busy_o     (busy_o),
    .count_o    (count_o)
  );

  always @(negedge clk) begin
    if (frame_err_o) fe_seen++;
    if (valid_o) valid_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (B) @(posedge clk);
    #1;
  endtask

  task automatic send_data_bits(input logic [7:0] b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_data_bits(b);
    drive_bit(1'b1);
  endtask

  task automatic pop_one();
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int fe0;
    int vs0;
    logic got;
    logic [7:0] seen_byte;

    fill_tbl[0] = '{8'h00, 3'd1, 1'b0};
    fill_tbl[1] = '{8'hFF, 3'd2, 1'b0};
    fill_tbl[2] = '{8'hA5, 3'd3, 1'b0};
    fill_tbl[3] = '{8'h3C, 3'd4, 1'b0};
    fill_tbl[4] = '{8'h77, 3'd4, 1'b1};
    pop_tbl[0] = 8'h00; pop_tbl[1] = 8'hFF; pop_tbl[2] = 8'hA5; pop_tbl[3] = 8'h3C;
    pat_tbl[0] = 8'h01; pat_tbl[1] = 8'h80; pat_tbl[2] = 8'hE7;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte", byte_o, 8'h00);
    check("rst_valid", valid_o, 1'b0);
    check("rst_count", count_o, 3'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ovf", overflow_o, 1'b0);
    check("rst_ferr", frame_err_o, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Single 0x55 with ready high: latency and one-cycle valid
    ready = 1'b1;
    n = 0;
    got = 1'b0;
    seen_byte = 8'h00;
    vs0 = valid_seen;
    fork
      send_frame(8'h55);
      begin
        while (!got && n < 200) begin
          @(posedge clk);
          #1;
          n++;
          if (valid_o) begin
            got = 1'b1;
            seen_byte = byte_o;
          end
        end
      end
    join
    ready = 1'b0;
    lat = n;
    checks++;
    if (!(n >= 77 && n <= 79)) begin
      errors++;
      $display("FAIL t1_push_latency: got %0d cycles expected 78 +-1", n);
    end
    check("t1_byte", seen_byte, 8'h55);
    check("t1_valid_cycles", valid_seen - vs0, 1);
    check("t1_valid_low", valid_o, 1'b0);

    // Distinct bit patterns, one at a time
    for (int i = 0; i < 3; i++) begin
      send_frame(pat_tbl[i]);
      check("pat_count", count_o, 3'd1);
      check("pat_byte", byte_o, pat_tbl[i]);
      pop_one();
      check("pat_empty", valid_o, 1'b0);
    end

    // Pop and push on the same edge
    send_frame(8'h11);
    send_frame(8'h22);
    check("pp_pre_count", count_o, 3'd2);
    check("pp_pre_byte", byte_o, 8'h11);
    fork
      send_frame(8'h33);
      begin
        repeat (lat - 1) @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
      end
    join
    check("pp_count", count_o, 3'd2);
    check("pp_head", byte_o, 8'h22);
    pop_one();
    check("pp_head2", byte_o, 8'h33);
    pop_one();
    check("pp_drained", count_o, 3'd0);

    // Fill to depth, then overflow on the fifth byte
    for (int i = 0; i < 5; i++) begin
      send_frame(fill_tbl[i].tx);
      check("fill_count", count_o, fill_tbl[i].exp_count);
      check("fill_ovf", overflow_o, fill_tbl[i].exp_ovf);
    end
    repeat (5) @(posedge clk);
    #1;
    check("hold_byte", byte_o, 8'h00);
    check("hold_valid", valid_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("pop_byte", byte_o, pop_tbl[i]);
      pop_one();
      check("pop_count", count_o, 3 - i);
    end
    check("ovf_sticky", overflow_o, 1'b1);
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ready = 1'b0;
    check("pop_empty_count", count_o, 3'd0);

    // Stop bit held low for 16 cycles
    fe0 = fe_seen;
    vs0 = valid_seen;
    send_data_bits(8'hC3);
    uart_rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("brk_busy", busy_o, 1'b1);
    check("brk_ferr_once", fe_seen - fe0, 1);
    uart_rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("brk_idle", busy_o, 1'b0);
    check("brk_ferr_total", fe_seen - fe0, 1);
    check("brk_no_push", valid_seen - vs0, 0);

    // Three-cycle glitch on an idle line
    fe0 = fe_seen;
    vs0 = valid_seen;
    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    check("gl_busy", busy_o, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("gl_idle", busy_o, 1'b0);
    check("gl_no_push", valid_seen - vs0, 0);
    check("gl_no_ferr", fe_seen - fe0, 0);

    // Reset during data bit 4 with a byte queued
    send_frame(8'h5A);
    check("mr_pre_count", count_o, 3'd1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mr_pre_busy", busy_o, 1'b1);
    rst = 1'b1;
    #1;
    check("mr_byte", byte_o, 8'h00);
    check("mr_valid", valid_o, 1'b0);
    check("mr_count", count_o, 3'd0);
    check("mr_busy", busy_o, 1'b0);
    check("mr_ovf", overflow_o, 1'b0);
    uart_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fe0 = fe_seen;
    send_frame(8'h81);
    check("mr_rx_count", count_o, 3'd1);
    check("mr_rx_byte", byte_o, 8'h81);
    check("mr_rx_ferr", fe_seen - fe0, 0);
    pop_one();
    check("mr_drained", count_o, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
